param_deserializer: RTL and testbench

- Parametrised successor to the team's 8-bit serial-to-parallel receiver.
- Shifts in WIDTH-bit words one bit per write_in strobe, in a selectable bit order (MSB-first or LSB-first).
- Completed words go into a DEPTH-entry output FIFO. Reception continues while earlier words wait for ack_in, so there is no IDLE/READY stall.
- Sits between the serial link front-end and the downstream word queue consumer; adds fill level, busy and sticky overflow reporting.

---
 rtl/param_deserializer.sv | 153 +++++++++++++++
 tb/tb_param_deserializer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_deserializer.sv
// Serial-to-parallel receiver: shifts WIDTH-bit words in one bit per strobe and
// queues completed words in a DEPTH-entry FIFO with level, busy and sticky overflow.
module param_deserializer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                         clock_100,
    input  logic                         reset,
    input  logic                         data_in,
    input  logic                         write_in,
    input  logic                         ack_in,
    input  logic                         clear_err,
    output logic [WIDTH-1:0]             data_out,
    output logic                         data_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         status_out,
    output logic                         overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    // Pointers wrap modulo DEPTH; with DEPTH=1 they stay at zero.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    logic [WIDTH-1:0] shreg_r;
    logic [CNT_W-1:0] bit_cnt_r;
    logic             status_r;
    logic [WIDTH-1:0] mem_r [0:DEPTH-1];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic [WIDTH-1:0] data_out_r;
    logic             data_ready_r;
    logic             overflow_r;

    logic [WIDTH-1:0] shreg_next_s;
    logic [CNT_W-1:0] bit_cnt_next_s;
    logic             word_done_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             ovf_set_s;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic [PTR_W-1:0] wr_ptr_next_s;
    logic [LVL_W-1:0] level_next_s;
    logic [WIDTH-1:0] head_next_s;

    // Shift register and bit counter next state; a word completes on the last bit.
    always_comb begin
        shreg_next_s   = shreg_r;
        bit_cnt_next_s = bit_cnt_r;
        word_done_s    = 1'b0;
        if (write_in) begin
            if (MSB_FIRST) begin
                shreg_next_s = {shreg_r[WIDTH-2:0], data_in};
            end else begin
                shreg_next_s = {data_in, shreg_r[WIDTH-1:1]};
            end
            if (bit_cnt_r == CNT_W'(WIDTH - 1)) begin
                bit_cnt_next_s = {CNT_W{1'b0}};
                word_done_s    = 1'b1;
            end else begin
                bit_cnt_next_s = bit_cnt_r + CNT_W'(1);
            end
        end else begin
            shreg_next_s   = shreg_r;
            bit_cnt_next_s = bit_cnt_r;
        end
    end

    // FIFO control: a pop in the same edge frees room, so a full FIFO does not overflow.
    always_comb begin
        full_s        = (level_r == LVL_W'(DEPTH));
        pop_s         = ack_in && (level_r != {LVL_W{1'b0}});
        push_s        = word_done_s && (!full_s || pop_s);
        ovf_set_s     = word_done_s && full_s && !pop_s;
        rd_ptr_next_s = pop_s  ? ptr_inc(rd_ptr_r) : rd_ptr_r;
        wr_ptr_next_s = push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LVL_W'(1);
            2'b01:   level_next_s = level_r - LVL_W'(1);
            default: level_next_s = level_r;
        endcase
        // Next head: the word being written lands at the head when it becomes the oldest entry.
        if (level_next_s == {LVL_W{1'b0}}) begin
            head_next_s = {WIDTH{1'b0}};
        end else if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = shreg_next_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Shift register, bit counter and busy flag.
    always_ff @(posedge clock_100 or negedge reset) begin
        if (!reset) begin
            shreg_r   <= {WIDTH{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            status_r  <= 1'b0;
        end else begin
            shreg_r   <= shreg_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            status_r  <= (bit_cnt_next_s != {CNT_W{1'b0}});
        end
    end

    // FIFO storage, pointers, registered head and sticky overflow.
    always_ff @(posedge clock_100 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            rd_ptr_r     <= {PTR_W{1'b0}};
            wr_ptr_r     <= {PTR_W{1'b0}};
            level_r      <= {LVL_W{1'b0}};
            data_out_r   <= {WIDTH{1'b0}};
            data_ready_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= shreg_next_s;
            end
            rd_ptr_r     <= rd_ptr_next_s;
            wr_ptr_r     <= wr_ptr_next_s;
            level_r      <= level_next_s;
            data_out_r   <= head_next_s;
            data_ready_r <= (level_next_s != {LVL_W{1'b0}});
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (clear_err) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign data_out   = data_out_r;
    assign data_ready = data_ready_r;
    assign level      = level_r;
    assign status_out = status_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_param_deserializer.sv
// Bench for param_deserializer: an MSB-first and an LSB-first instance (WIDTH=8, DEPTH=2)
// share one bit stream and are checked against a queue-based reference model.
module tb_param_deserializer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic data_in = 1'b0;
    logic write_in = 1'b0;
    logic ack_in = 1'b0;
    logic clear_err = 1'b0;

    logic [7:0] dout_m, dout_l;
    logic       rdy_m, rdy_l, st_m, st_l, ov_m, ov_l;
    logic [1:0] lvl_m, lvl_l;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state
    bit         bits[$];
    logic [7:0] qm[$];
    logic [7:0] ql[$];
    bit         ovf = 1'b0;

    always #5 clk = ~clk;

    param_deserializer #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(1'b1)) dut_m (
        .clock_100(clk), .reset(reset), .data_in(data_in), .write_in(write_in),
        .ack_in(ack_in), .clear_err(clear_err), .data_out(dout_m), .data_ready(rdy_m),
        .level(lvl_m), .status_out(st_m), .overflow(ov_m));

    param_deserializer #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(1'b0)) dut_l (
        .clock_100(clk), .reset(reset), .data_in(data_in), .write_in(write_in),
        .ack_in(ack_in), .clear_err(clear_err), .data_out(dout_l), .data_ready(rdy_l),
        .level(lvl_l), .status_out(st_l), .overflow(ov_l));

    wire [25:0] obs_vec = {dout_m, dout_l, rdy_m, rdy_l, lvl_m, lvl_l, st_m, st_l, ov_m, ov_l};

    function automatic logic [25:0] exp_vec();
        logic [7:0] em, el;
        logic [1:0] lv;
        logic r, s;
        em = (qm.size() != 0) ? qm[0] : 8'h00;
        el = (ql.size() != 0) ? ql[0] : 8'h00;
        lv = 2'(qm.size());
        r  = (qm.size() != 0);
        s  = (bits.size() != 0);
        return {em, el, r, r, lv, lv, s, s, ovf, ovf};
    endfunction

    task automatic model_clear();
        bits.delete();
        qm.delete();
        ql.delete();
        ovf = 1'b0;
    endtask

    // One clock: update the model from the inputs the DUT samples, return at the falling edge.
    task automatic tick();
        bit pop, done, set;
        logic [7:0] wm, wl;
        @(posedge clk);
        pop = 1'b0; done = 1'b0; set = 1'b0; wm = 8'h00; wl = 8'h00;
        if (!reset) begin
            model_clear();
        end else begin
            pop = ack_in && (qm.size() > 0);
            if (write_in) begin
                bits.push_back(data_in);
                if (bits.size() == 8) begin
                    done = 1'b1;
                    for (int i = 0; i < 8; i++) begin
                        wm[7-i] = bits[i];
                        wl[i]   = bits[i];
                    end
                    bits.delete();
                end
            end
            if (pop) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (done) begin
                if (qm.size() < 2) begin
                    qm.push_back(wm);
                    ql.push_back(wl);
                end else begin
                    set = 1'b1;
                end
            end
            if (set) ovf = 1'b1;
            else if (clear_err) ovf = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] w, input int gap);
        for (int i = 7; i >= 0; i--) begin
            write_in = 1'b1;
            data_in  = w[i];
            tick();
            write_in = 1'b0;
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        n_total++;
        if (obs_vec !== 26'd0) $display("FAIL reset_outputs: got %h want %h", obs_vec, 26'd0);
        else n_pass++;
        reset = 1'b1;
        tick();
        n_total++;
        if (obs_vec !== exp_vec()) $display("FAIL after_release: got %h want %h", obs_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_bit_order();
        logic [7:0] stream;
        stream = 8'b1011_0010;
        send_word(stream, 0);
        n_total++;
        if (dout_m !== 8'hB2 || dout_l !== 8'h4D)
            $display("FAIL bit_order: got m=%h l=%h want m=b2 l=4d", dout_m, dout_l);
        else n_pass++;
        n_total++;
        if (rdy_m !== 1'b1 || lvl_m !== 2'd1 || st_m !== 1'b0)
            $display("FAIL first_word_flags: got rdy=%b lvl=%0d st=%b want 1 1 0", rdy_m, lvl_m, st_m);
        else n_pass++;
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        n_total++;
        if (rdy_m !== 1'b0 || dout_m !== 8'h00 || lvl_m !== 2'd0)
            $display("FAIL pop_to_empty: got rdy=%b dout=%h lvl=%0d want 0 00 0", rdy_m, dout_m, lvl_m);
        else n_pass++;
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        n_total++;
        if (obs_vec !== exp_vec()) $display("FAIL ack_while_empty: got %h want %h", obs_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_overflow(input int gap);
        send_word(8'hA5, gap);
        send_word(8'h3C, gap);
        send_word(8'hFF, gap);
        n_total++;
        if (lvl_m !== 2'd2 || ov_m !== 1'b1 || dout_m !== 8'hA5)
            $display("FAIL overflow_gap%0d: got lvl=%0d ov=%b head=%h want 2 1 a5", gap, lvl_m, ov_m, dout_m);
        else n_pass++;
        n_total++;
        if (obs_vec !== exp_vec()) $display("FAIL overflow_model_gap%0d: got %h want %h", gap, obs_vec, exp_vec());
        else n_pass++;
        ack_in = 1'b1;
        tick();
        n_total++;
        if (dout_m !== 8'h3C || lvl_m !== 2'd1)
            $display("FAIL second_head_gap%0d: got %h lvl=%0d want 3c 1", gap, dout_m, lvl_m);
        else n_pass++;
        tick();
        ack_in = 1'b0;
        n_total++;
        if (lvl_m !== 2'd0 || rdy_m !== 1'b0 || ov_m !== 1'b1)
            $display("FAIL drained_gap%0d: got lvl=%0d rdy=%b ov=%b want 0 0 1", gap, lvl_m, rdy_m, ov_m);
        else n_pass++;
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        n_total++;
        if (ov_m !== 1'b0 || ov_l !== 1'b0)
            $display("FAIL clear_err_gap%0d: got %b%b want 00", gap, ov_m, ov_l);
        else n_pass++;
    endtask

    task automatic test_gaps();
        logic [7:0] w;
        int bad;
        bad = 0;
        w = 8'h5A;
        for (int i = 7; i >= 0; i--) begin
            write_in = 1'b1;
            data_in  = w[i];
            tick();
            write_in = 1'b0;
            if (st_m !== (i != 0) || obs_vec !== exp_vec()) bad++;
            for (int g = 0; g < 3; g++) begin
                tick();
                if (st_m !== (i != 0) || obs_vec !== exp_vec()) bad++;
            end
        end
        n_total++;
        if (bad != 0) $display("FAIL gap_busy: got %0d bad cycles want 0", bad);
        else n_pass++;
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        test_overflow(3);
    endtask

    task automatic test_async_reset();
        logic [7:0] w;
        w = 8'hC3;
        send_word(8'h96, 0);
        for (int i = 7; i >= 3; i--) begin
            write_in = 1'b1;
            data_in  = w[i];
            tick();
        end
        write_in = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_total++;
        if (obs_vec !== 26'd0) $display("FAIL async_reset: got %h want %h", obs_vec, 26'd0);
        else n_pass++;
        model_clear();
        tick();
        reset = 1'b1;
        send_word(8'hF0, 0);
        n_total++;
        if (dout_m !== 8'hF0 || dout_l !== 8'h0F || lvl_m !== 2'd1)
            $display("FAIL after_reset_word: got m=%h l=%h lvl=%0d want f0 0f 1", dout_m, dout_l, lvl_m);
        else n_pass++;
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
    endtask

    task automatic test_push_pop_full();
        logic [7:0] w;
        w = 8'h81;
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        for (int i = 7; i >= 1; i--) begin
            write_in = 1'b1;
            data_in  = w[i];
            tick();
        end
        data_in = w[0];
        ack_in  = 1'b1;
        tick();
        write_in = 1'b0;
        ack_in   = 1'b0;
        n_total++;
        if (ov_m !== 1'b0 || lvl_m !== 2'd2 || dout_m !== 8'h3C)
            $display("FAIL full_push_pop: got ov=%b lvl=%0d head=%h want 0 2 3c", ov_m, lvl_m, dout_m);
        else n_pass++;
        ack_in = 1'b1;
        tick();
        n_total++;
        if (dout_m !== 8'h81 || dout_l !== 8'h81 || lvl_m !== 2'd1)
            $display("FAIL full_second: got m=%h l=%h lvl=%0d want 81 81 1", dout_m, dout_l, lvl_m);
        else n_pass++;
        tick();
        ack_in = 1'b0;
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int c = 0; c < 3000; c++) begin
            write_in  = ($urandom_range(0, 3) != 0);
            data_in   = $urandom_range(0, 1);
            ack_in    = ($urandom_range(0, 4) == 0);
            clear_err = ($urandom_range(0, 15) == 0);
            tick();
            if (obs_vec !== exp_vec()) begin
                bad++;
                if (bad <= 5) $display("FAIL random_cycle_%0d: got %h want %h", c, obs_vec, exp_vec());
            end
        end
        write_in = 1'b0; ack_in = 1'b0; clear_err = 1'b0;
        n_total++;
        if (bad != 0) $display("FAIL random: got %0d bad cycles want 0", bad);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_bit_order();
        test_overflow(0);
        test_gaps();
        test_async_reset();
        test_push_pop_full();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
